aclk_alarm_reg: RTL and testbench

// Alarm-time holding register for the 24-hour alarm clock.
// - Captures a new 4-digit BCD alarm time (HH:MM) from the keypad/key-register path when load_new_alarm is asserted.
// - Holds it and presents it continuously to the alarm comparator and display mux.
// - Rejects out-of-range times so the stored alarm is always a legal 24-hour time.
//

---
 rtl/aclk_alarm_reg_if.sv | 19 +
 rtl/aclk_alarm_reg.sv | 77 +++++++
 tb/tb_aclk_alarm_reg.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aclk_alarm_reg_if.sv
// Alarm-time bus: candidate BCD time (HH:MM digits packed MSB-first), load strobe and stored alarm.
// The master side (keypad/key-register path) drives the candidate; the slave side holds the alarm.
interface aclk_alarm_reg_if;
    logic [15:0] new_time_dat;
    logic        load_vld;
    logic [15:0] alarm_time_dat;

    modport master (
        output new_time_dat,
        output load_vld,
        input  alarm_time_dat
    );

    modport slave (
        input  new_time_dat,
        input  load_vld,
        output alarm_time_dat
    );
endinterface

// File: rtl/aclk_alarm_reg.sv
// Alarm-time register: captures a legal 24h BCD HH:MM on the load strobe, 1-cycle latency.
// No backpressure: the strobe is sampled every edge; out-of-range candidates are dropped whole.
module aclk_alarm_reg_core #(
    parameter int CHECK_VALID = 1
) (
    input  logic           clk,
    input  logic           rst,
    aclk_alarm_reg_if.slave bus
);
    logic [15:0] alarm_d;
    logic [15:0] alarm_q;
    logic [3:0]  ms_hr;
    logic [3:0]  ls_hr;
    logic [3:0]  ms_min;
    logic [3:0]  ls_min;
    logic        time_ok;

    always_comb begin
        ms_hr   = bus.new_time_dat[15:12];
        ls_hr   = bus.new_time_dat[11:8];
        ms_min  = bus.new_time_dat[7:4];
        ls_min  = bus.new_time_dat[3:0];
        // 20..23 is the only decade where the units digit is capped below 9
        time_ok = (ms_hr <= 4'd2) && (ls_hr <= 4'd9) &&
                  (ms_min <= 4'd5) && (ls_min <= 4'd9) &&
                  !((ms_hr == 4'd2) && (ls_hr > 4'd3));
        alarm_d = alarm_q;
        if (bus.load_vld && ((CHECK_VALID == 0) || time_ok)) begin
            alarm_d = bus.new_time_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 16'd0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign bus.alarm_time_dat = alarm_q;
endmodule

module aclk_alarm_reg #(
    parameter int CHECK_VALID = 1
) (
    input  logic [3:0] new_alarm_ms_hr,
    input  logic [3:0] new_alarm_ls_hr,
    input  logic [3:0] new_alarm_ms_min,
    input  logic [3:0] new_alarm_ls_min,
    input  logic       load_new_alarm,
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] alarm_time_ms_hr,
    output logic [3:0] alarm_time_ls_hr,
    output logic [3:0] alarm_time_ms_min,
    output logic [3:0] alarm_time_ls_min
);
    aclk_alarm_reg_if bus ();

    assign bus.new_time_dat = {new_alarm_ms_hr, new_alarm_ls_hr,
                               new_alarm_ms_min, new_alarm_ls_min};
    assign bus.load_vld     = load_new_alarm;

    aclk_alarm_reg_core #(
        .CHECK_VALID (CHECK_VALID)
    ) u_core (
        .clk (clock),
        .rst (reset),
        .bus (bus)
    );

    assign alarm_time_ms_hr  = bus.alarm_time_dat[15:12];
    assign alarm_time_ls_hr  = bus.alarm_time_dat[11:8];
    assign alarm_time_ms_min = bus.alarm_time_dat[7:4];
    assign alarm_time_ls_min = bus.alarm_time_dat[3:0];
endmodule

// File: tb/tb_aclk_alarm_reg.sv
// Bench for the alarm register: directed scenarios plus randomized loads/resets against an
// arithmetic model (hours < 24, minutes < 60), for both the checked and unchecked variants.
module tb_aclk_alarm_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;

    aclk_alarm_reg_if bus ();

    wire [3:0] c_mh, c_lh, c_mm, c_lm;
    wire [3:0] u_mh, u_lh, u_mm, u_lm;
    wire [15:0] out_c = {c_mh, c_lh, c_mm, c_lm};
    wire [15:0] out_u = {u_mh, u_lh, u_mm, u_lm};

    assign bus.alarm_time_dat = out_c;

    aclk_alarm_reg #(.CHECK_VALID(1)) dut (
        .new_alarm_ms_hr   (bus.new_time_dat[15:12]),
        .new_alarm_ls_hr   (bus.new_time_dat[11:8]),
        .new_alarm_ms_min  (bus.new_time_dat[7:4]),
        .new_alarm_ls_min  (bus.new_time_dat[3:0]),
        .load_new_alarm    (bus.load_vld),
        .clock             (clk),
        .reset             (rst),
        .alarm_time_ms_hr  (c_mh),
        .alarm_time_ls_hr  (c_lh),
        .alarm_time_ms_min (c_mm),
        .alarm_time_ls_min (c_lm)
    );

    aclk_alarm_reg #(.CHECK_VALID(0)) dut_unchk (
        .new_alarm_ms_hr   (bus.new_time_dat[15:12]),
        .new_alarm_ls_hr   (bus.new_time_dat[11:8]),
        .new_alarm_ms_min  (bus.new_time_dat[7:4]),
        .new_alarm_ls_min  (bus.new_time_dat[3:0]),
        .load_new_alarm    (bus.load_vld),
        .clock             (clk),
        .reset             (rst),
        .alarm_time_ms_hr  (u_mh),
        .alarm_time_ls_hr  (u_lh),
        .alarm_time_ms_min (u_mm),
        .alarm_time_ls_min (u_lm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_c = 16'h0000;
    logic [15:0] exp_u = 16'h0000;

    function automatic bit legal_time(input logic [15:0] t);
        int hours;
        int mins;
        hours = int'(t[15:12]) * 10 + int'(t[11:8]);
        mins  = int'(t[7:4]) * 10 + int'(t[3:0]);
        return (t[15:12] <= 9) && (t[11:8] <= 9) && (t[7:4] <= 9) && (t[3:0] <= 9) &&
               (hours < 24) && (mins < 60);
    endfunction

    // One clock edge with the given inputs; entered and left at a falling edge.
    task automatic step(input logic [15:0] d, input logic ld);
        bus.new_time_dat = d;
        bus.load_vld     = ld;
        @(posedge clk);
        if (rst) begin
            exp_c = 16'h0000;
            exp_u = 16'h0000;
        end else if (ld) begin
            if (legal_time(d)) exp_c = d;
            exp_u = d;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.new_time_dat = 16'h1230;
        bus.load_vld     = 1'b1;
        rst = 1'b1;
        #2;
        n_cmp++;
        if (out_c !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_early: got %h want 0000", out_c);
        end
        step(16'h1230, 1'b1);
        step(16'h2359, 1'b1);
        n_cmp++;
        if (out_c !== 16'h0000 || out_u !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_held_with_load: got %h/%h want 0000", out_c, out_u);
        end
        rst = 1'b0;
        step(16'h1111, 1'b0);
        n_cmp++;
        if (out_c !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_after_release: got %h want 0000", out_c);
        end
    endtask

    task automatic test_load_hold();
        step(16'h1230, 1'b1);
        n_cmp++;
        if (out_c !== 16'h1230) begin
            n_err++;
            $display("FAIL load_1230: got %h want 1230", out_c);
        end
        for (int i = 0; i < 5; i++) begin
            step(16'h0000 + 16'(i * 16'h0411), 1'b0);
            n_cmp++;
            if (out_c !== 16'h1230) begin
                n_err++;
                $display("FAIL hold_1230 cyc %0d: got %h want 1230", i, out_c);
            end
        end
        step(16'h1045, 1'b1);
        n_cmp++;
        if (out_c !== 16'h1045) begin
            n_err++;
            $display("FAIL load_1045: got %h want 1045", out_c);
        end
        step(16'h0840, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(16'h1959, 1'b0);
            n_cmp++;
            if (out_c !== 16'h0840) begin
                n_err++;
                $display("FAIL hold_0840 cyc %0d: got %h want 0840", i, out_c);
            end
        end
    endtask

    task automatic test_invalid();
        logic [15:0] bad [6];
        bad[0] = 16'h2500; bad[1] = 16'h1260; bad[2] = 16'h2400;
        bad[3] = 16'h3000; bad[4] = 16'h0A00; bad[5] = 16'h000A;
        for (int i = 0; i < 6; i++) begin
            step(bad[i], 1'b1);
            n_cmp++;
            if (out_c !== 16'h0840) begin
                n_err++;
                $display("FAIL reject_%h: got %h want 0840", bad[i], out_c);
            end
            n_cmp++;
            if (out_u !== bad[i]) begin
                n_err++;
                $display("FAIL unchecked_%h: got %h want %h", bad[i], out_u, bad[i]);
            end
        end
        step(16'h2359, 1'b1);
        n_cmp++;
        if (out_c !== 16'h2359) begin
            n_err++;
            $display("FAIL load_2359: got %h want 2359", out_c);
        end
        step(16'h0000, 1'b1);
        n_cmp++;
        if (out_c !== 16'h0000) begin
            n_err++;
            $display("FAIL load_0000: got %h want 0000", out_c);
        end
        step(16'h2359, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [3];
        seq[0] = 16'h0101; seq[1] = 16'h2250; seq[2] = 16'h1909;
        for (int i = 0; i < 3; i++) begin
            step(seq[i], 1'b1);
            n_cmp++;
            if (out_c !== seq[i]) begin
                n_err++;
                $display("FAIL b2b_%0d: got %h want %h", i, out_c, seq[i]);
            end
        end
        step(16'h2359, 1'b1);
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        n_cmp++;
        if (out_c !== 16'h2359) begin
            n_err++;
            $display("FAIL pre_async_hold: got %h want 2359", out_c);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_c !== 16'h0000 || out_u !== 16'h0000) begin
            n_err++;
            $display("FAIL async_reset_immediate: got %h/%h want 0000", out_c, out_u);
        end
        rst = 1'b0;
        exp_c = 16'h0000;
        exp_u = 16'h0000;
        @(negedge clk);
        step(16'h1234, 1'b0);
        n_cmp++;
        if (out_c !== 16'h0000) begin
            n_err++;
            $display("FAIL async_reset_stays: got %h want 0000", out_c);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic        ld;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0)
                d = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
            else
                d = 16'($urandom);
            ld  = 1'($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 39) == 0);
            step(d, ld);
            rst = 1'b0;
            n_cmp++;
            if (out_c !== exp_c) begin
                n_err++;
                $display("FAIL rand_chk %0d: got %h want %h", i, out_c, exp_c);
            end
            n_cmp++;
            if (out_u !== exp_u) begin
                n_err++;
                $display("FAIL rand_unchk %0d: got %h want %h", i, out_u, exp_u);
            end
        end
    endtask

    initial begin
        bus.new_time_dat = 16'h0000;
        bus.load_vld     = 1'b0;
        test_reset();
        test_load_hold();
        test_invalid();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
